exc_unit: RTL and testbench

//  Exception arbiter on the MEM/WB boundary, and the initiator side of the cp0 exception port.

---
 rtl/exc_unit.sv | 197 +++++++++++++++++++
 tb/tb_exc_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Exception arbiter at MEM/WB: picks one winner, drives the cp0 exception port, flushes and redirects fetch.
// Optional taken-exception counter is built only when EXC_STAT_EN is defined.
`ifndef EXC_T_DEFS
`define EXC_T_DEFS
`define ExcT        3:0
`define ExcT_Intr   4'd0
`define ExcT_AdEL1  4'd1
`define ExcT_RI     4'd2
`define ExcT_Ov     4'd3
`define ExcT_SysC   4'd4
`define ExcT_Bp     4'd5
`define ExcT_ERET   4'd6
`define ExcT_AdEL2  4'd7
`define ExcT_AdES   4'd8
`endif

module exc_unit #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mem_valid_i,
    input  logic           mem_stall_i,
    input  logic [31:0]    mem_pc_i,
    input  logic           mem_inslot_i,
    input  logic [7:0]     mem_exc_i,
    input  logic [31:0]    mem_baddr_i,
    input  logic           cp0_intr_req_i,
    input  logic [31:0]    status_i,
    input  logic [31:0]    epc_i,
    input  logic           if_ack_i,
    output logic           cp0_exc_flag_o,
    output logic [`ExcT]   cp0_exc_type_o,
    output logic [31:0]    cp0_pc_o,
    output logic [31:0]    cp0_baddr_o,
    output logic           cp0_inslot_o,
    output logic           flush_o,
    output logic           redirect_valid_o,
    output logic [31:0]    redirect_pc_o,
    output logic           busy_o,
    output logic [31:0]    exc_count_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, HOLD} state_e;

    state_e       state_q, state_d;
    logic         flag_q, flag_d;
    logic         flush_q, flush_d;
    logic         rv_q, rv_d;
    logic         busy_q, busy_d;
    logic [`ExcT] type_q, type_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  baddr_q, baddr_d;
    logic         inslot_q, inslot_d;
    logic [31:0]  rpc_q, rpc_d;

    logic         take_c;
    logic [`ExcT] win_type_c;
    logic [31:0]  win_baddr_c;
    logic         unused_status_c;

    assign unused_status_c = ^{status_i[31:23], status_i[21:0]};

    assign take_c = mem_valid_i & ~mem_stall_i & (state_q == IDLE)
                  & (cp0_intr_req_i | (|mem_exc_i));

    // Fixed-priority winner select; interrupt outranks every synchronous cause
    always_comb begin
        win_type_c  = `ExcT_AdES;
        win_baddr_c = 32'd0;
        if (cp0_intr_req_i) begin
            win_type_c = `ExcT_Intr;
        end else if (mem_exc_i[0]) begin
            win_type_c  = `ExcT_AdEL1;
            win_baddr_c = mem_pc_i;
        end else if (mem_exc_i[1]) begin
            win_type_c = `ExcT_RI;
        end else if (mem_exc_i[2]) begin
            win_type_c = `ExcT_Ov;
        end else if (mem_exc_i[3]) begin
            win_type_c = `ExcT_SysC;
        end else if (mem_exc_i[4]) begin
            win_type_c = `ExcT_Bp;
        end else if (mem_exc_i[5]) begin
            win_type_c = `ExcT_ERET;
        end else if (mem_exc_i[6]) begin
            win_type_c  = `ExcT_AdEL2;
            win_baddr_c = mem_baddr_i;
        end else begin
            win_type_c  = `ExcT_AdES;
            win_baddr_c = mem_baddr_i;
        end
    end

    // Next state and registered outputs
    always_comb begin
        state_d  = state_q;
        flag_d   = 1'b0;
        flush_d  = 1'b0;
        rv_d     = rv_q;
        type_d   = type_q;
        pc_d     = pc_q;
        baddr_d  = baddr_q;
        inslot_d = inslot_q;
        rpc_d    = rpc_q;
        unique case (state_q)
            IDLE: begin
                rv_d = 1'b0;
                if (take_c) begin
                    state_d  = FLUSH;
                    flag_d   = 1'b1;
                    flush_d  = 1'b1;
                    rv_d     = 1'b1;
                    type_d   = win_type_c;
                    pc_d     = mem_pc_i;
                    baddr_d  = win_baddr_c;
                    inslot_d = mem_inslot_i;
                    rpc_d    = (win_type_c == `ExcT_ERET) ? epc_i
                             : (status_i[22] ? VEC_BEV1 : VEC_BEV0);
                end
            end
            FLUSH: begin
                state_d = if_ack_i ? IDLE : HOLD;
                rv_d    = ~if_ack_i;
            end
            HOLD: begin
                if (if_ack_i) begin
                    state_d = IDLE;
                    rv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rv_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            flag_q   <= 1'b0;
            flush_q  <= 1'b0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            type_q   <= '0;
            pc_q     <= 32'd0;
            baddr_q  <= 32'd0;
            inslot_q <= 1'b0;
            rpc_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            flush_q  <= flush_d;
            rv_q     <= rv_d;
            busy_q   <= busy_d;
            type_q   <= type_d;
            pc_q     <= pc_d;
            baddr_q  <= baddr_d;
            inslot_q <= inslot_d;
            rpc_q    <= rpc_d;
        end
    end

    assign cp0_exc_flag_o   = flag_q;
    assign cp0_exc_type_o   = type_q;
    assign cp0_pc_o         = pc_q;
    assign cp0_baddr_o      = baddr_q;
    assign cp0_inslot_o     = inslot_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rpc_q;
    assign busy_o           = busy_q;

`ifdef EXC_STAT_EN
    logic [31:0] count_q, count_d;

    // Saturating count of taken exceptions; ERET is a return, not an exception
    always_comb begin
        count_d = count_q;
        if (take_c && (win_type_c != `ExcT_ERET) && (count_q != 32'hFFFF_FFFF))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= 32'd0;
        else        count_q <= count_d;
    end

    assign exc_count_o = count_q;
`else
    assign exc_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_exc_unit.sv
// Directed plus randomized bench for exc_unit, checked against a cause-level reference model.
`ifndef EXC_T_DEFS
`define EXC_T_DEFS
`define ExcT        3:0
`define ExcT_Intr   4'd0
`define ExcT_AdEL1  4'd1
`define ExcT_RI     4'd2
`define ExcT_Ov     4'd3
`define ExcT_SysC   4'd4
`define ExcT_Bp     4'd5
`define ExcT_ERET   4'd6
`define ExcT_AdEL2  4'd7
`define ExcT_AdES   4'd8
`endif

module tb_exc_unit;
    localparam logic [31:0] V1 = 32'hBFC00380;
    localparam logic [31:0] V0 = 32'h80000180;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_valid, mem_stall, mem_inslot, intr, if_ack;
    logic [31:0] mem_pc, mem_baddr, status, epc;
    logic [7:0] mem_exc;
    logic cp0_exc_flag, cp0_inslot, flush, redirect_valid, busy;
    logic [`ExcT] cp0_exc_type;
    logic [31:0] cp0_pc, cp0_baddr, redirect_pc, exc_count;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: what the outputs must show after the next edge
    logic e_flag, e_rv, e_busy, e_inslot;
    logic [`ExcT] e_type;
    logic [31:0] e_pc, e_baddr, e_rpc, e_cnt;

    always #5 clk = ~clk;

    exc_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid_i(mem_valid), .mem_stall_i(mem_stall), .mem_pc_i(mem_pc),
        .mem_inslot_i(mem_inslot), .mem_exc_i(mem_exc), .mem_baddr_i(mem_baddr),
        .cp0_intr_req_i(intr), .status_i(status), .epc_i(epc), .if_ack_i(if_ack),
        .cp0_exc_flag_o(cp0_exc_flag), .cp0_exc_type_o(cp0_exc_type),
        .cp0_pc_o(cp0_pc), .cp0_baddr_o(cp0_baddr), .cp0_inslot_o(cp0_inslot),
        .flush_o(flush), .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .busy_o(busy), .exc_count_o(exc_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cause_type(input int idx);
        case (idx)
            0: return `ExcT_AdEL1;
            1: return `ExcT_RI;
            2: return `ExcT_Ov;
            3: return `ExcT_SysC;
            4: return `ExcT_Bp;
            5: return `ExcT_ERET;
            6: return `ExcT_AdEL2;
            default: return `ExcT_AdES;
        endcase
    endfunction

    task automatic model_reset();
        e_flag = 0; e_rv = 0; e_busy = 0; e_inslot = 0;
        e_type = '0; e_pc = 0; e_baddr = 0; e_rpc = 0; e_cnt = 0;
    endtask

    task automatic check_all();
        chk("flag", 32'(cp0_exc_flag), 32'(e_flag));
        chk("flush", 32'(flush), 32'(e_flag));
        chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("exc_count", exc_count, e_cnt);
        if (e_flag) begin
            chk("type", 32'(cp0_exc_type), 32'(e_type));
            chk("cp0_pc", cp0_pc, e_pc);
            chk("baddr", cp0_baddr, e_baddr);
            chk("inslot", 32'(cp0_inslot), 32'(e_inslot));
        end
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
    endtask

    // one clock: predict from current inputs, advance, compare
    task automatic step();
        int w;
        w = -1;
        if (mem_valid && !mem_stall && !e_busy && (intr || mem_exc != 8'd0)) begin
            if (!intr)
                for (int i = 7; i >= 0; i--) if (mem_exc[i]) w = i;
            e_type   = intr ? `ExcT_Intr : cause_type(w);
            e_baddr  = (w == 0) ? mem_pc : (w >= 6) ? mem_baddr : 32'd0;
            e_pc     = mem_pc;
            e_inslot = mem_inslot;
            e_rpc    = (w == 5) ? epc : (status[22] ? V1 : V0);
`ifdef EXC_STAT_EN
            if (w != 5 && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
`endif
            e_flag = 1; e_rv = 1; e_busy = 1;
        end else begin
            e_flag = 0;
            if (e_busy && if_ack) begin
                e_busy = 0; e_rv = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_stall = 0; mem_exc = 8'd0; intr = 0; if_ack = 0;
    endtask

    task automatic drain();
        idle_inputs();
        if_ack = 1;
        step();
        step();
        if_ack = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        mem_inslot = 0; mem_pc = 0; mem_baddr = 0; status = 0; epc = 0;
        model_reset();
        #2;
        chk("rst_flag", 32'(cp0_exc_flag), 0);
        chk("rst_type", 32'(cp0_exc_type), 0);
        chk("rst_pc", cp0_pc, 0);
        chk("rst_baddr", cp0_baddr, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Ov with BEV=1
        mem_valid = 1; mem_exc = 8'h04; mem_pc = 32'hBFC00100; status = 32'h0040_0000;
        step();
        chk("t1_type", 32'(cp0_exc_type), 32'(`ExcT_Ov));
        chk("t1_redirect", redirect_pc, V1);
        drain();

        // ERET redirects to EPC
        mem_valid = 1; mem_exc = 8'h20; epc = 32'h80001000; status = 0;
        step();
        chk("t2_redirect", redirect_pc, 32'h80001000);
        drain();

        // AdEL1 beats AdEL2
        mem_valid = 1; mem_exc = 8'h41; mem_pc = 32'h80000003; mem_baddr = 32'h12345678;
        step();
        chk("t3_baddr", cp0_baddr, 32'h80000003);
        drain();

        // interrupt waits for a valid instruction, then beats SysC
        intr = 1;
        repeat (3) step();
        mem_valid = 1; mem_exc = 8'h08; mem_pc = 32'h80000040; mem_inslot = 1;
        step();
        chk("t4_type", 32'(cp0_exc_type), 32'(`ExcT_Intr));
        intr = 0; mem_valid = 0; mem_exc = 0; mem_inslot = 0;
        step();
        drain();

        // held redirect, second Ov in HOLD ignored
        mem_valid = 1; mem_exc = 8'h04; mem_pc = 32'h80000200;
        step();
        mem_pc = 32'h80000300;
        repeat (4) step();
        chk("t5_hold_pc", redirect_pc, V0);
        mem_valid = 0; mem_exc = 0; if_ack = 1;
        step();
        chk("t5_idle", 32'(busy), 0);
        if_ack = 0;

        // stall holds off RI
        mem_valid = 1; mem_stall = 1; mem_exc = 8'h02; mem_pc = 32'h80000500;
        repeat (2) step();
        mem_stall = 0;
        step();
        drain();

        // ack in the flush cycle: no hold
        mem_valid = 1; mem_exc = 8'h10;
        step();
        mem_valid = 0; mem_exc = 0; if_ack = 1;
        step();
        if_ack = 0;
        step();

        // async reset while holding
        mem_valid = 1; mem_exc = 8'h80; mem_baddr = 32'hDEADBEE0;
        step();
        idle_inputs();
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("arst_type", 32'(cp0_exc_type), 0);
        @(negedge clk);
        rst_n = 1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            mem_valid  = ($urandom_range(0, 9) < 7);
            mem_stall  = ($urandom_range(0, 9) < 2);
            mem_exc    = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom() & $urandom());
            intr       = ($urandom_range(0, 9) < 2);
            if_ack     = ($urandom_range(0, 9) < 4);
            mem_inslot = 1'($urandom());
            mem_pc     = $urandom();
            mem_baddr  = $urandom();
            epc        = $urandom();
            status     = $urandom();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
